if_stage: RTL and testbench

Instruction-fetch stage. It owns the program counter, issues word fetches to instruction memory over a request/grant + response-valid handshake, and buffers returned words in a small FIFO. It drives the IF/ID pipeline register consumed by the decode stage. It accepts branch redirects (`ID_br_ctrl`, `ID_imm_addr`) and hazard stalls from decode, and flushes in-flight work on redirect.

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_stage_fetch_fifo.sv | 69 ++++++
 rtl/if_stage.sv | 176 +++++++++++++++++
 tb/tb_if_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, constants and fetch FSM encoding for the instruction-fetch stage.
package if_stage_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam int IMM_W  = 16;

    localparam logic [PC_W-1:0]   PC_STEP  = 32'd4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [0:0] {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    // Zero-extend a branch immediate to a full PC and force word alignment.
    function automatic logic [PC_W-1:0] branch_target(input logic [IMM_W-1:0] imm);
        return {16'h0000, imm & 16'hFFFC};
    endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush; depth must be a power of two.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against occupancy so the pointers can never overrun.
    always_comb begin
        do_push_s = push && (count_r != CW'(DEPTH));
        do_pop_s  = pop && (count_r != {CW{1'b0}});
    end

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !reset) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Status and head-of-queue read.
    always_comb begin
        rdata = mem_r[rd_ptr_r];
        count = count_r;
        full  = (count_r == CW'(DEPTH));
        empty = (count_r == {CW{1'b0}});
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: PC ownership, single-outstanding imem fetch, fetch buffer and IF/ID register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_br_ctrl,
    input  logic [IMM_W-1:0]  ID_imm_addr,
    input  logic              hdu_stall,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] ID_inst,
    output logic [PC_W-1:0]   ID_pc,
    output logic              ID_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_killed
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int ENT_W = PC_W + INST_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    fetch_state_e      state_r;
    fetch_state_e      state_next_s;
    logic [PC_W-1:0]   fetch_pc_r;
    logic [PC_W-1:0]   fetch_pc_next_s;
    logic [PC_W-1:0]   out_pc_r;
    logic              kill_r;
    logic              kill_next_s;
    logic              req_s;
    logic              grant_s;
    logic              push_s;
    logic              pop_s;
    logic [ENT_W-1:0]  head_s;
    logic [CNT_W-1:0]  count_s;
    logic              full_s;
    logic              empty_s;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENT_W)
    ) u_fetch_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (ID_br_ctrl),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({out_pc_r, imem_rdata}),
        .rdata (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Fetch FSM next state: one request outstanding; a redirect retargets and kills in-flight work.
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        kill_next_s     = kill_r;
        req_s           = 1'b0;
        grant_s         = 1'b0;
        push_s          = 1'b0;
        case (state_r)
            REQ: begin
                req_s   = !reset && (count_s < DEPTH_CNT);
                grant_s = req_s && imem_gnt;
                if (grant_s) begin
                    state_next_s    = WAIT;
                    fetch_pc_next_s = fetch_pc_r + PC_STEP;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next_s = REQ;
                    kill_next_s  = 1'b0;
                    push_s       = !kill_r && !ID_br_ctrl && !full_s;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = REQ;
                kill_next_s  = 1'b0;
            end
        endcase
        // A response still outstanding after this edge belongs to the old path.
        if (ID_br_ctrl) begin
            fetch_pc_next_s = branch_target(ID_imm_addr);
            kill_next_s     = kill_next_s || grant_s || ((state_r == WAIT) && !imem_rvalid);
        end else begin
            fetch_pc_next_s = fetch_pc_next_s;
        end
    end

    // Memory-side outputs and buffer dequeue decision.
    always_comb begin
        imem_req  = req_s;
        imem_addr = fetch_pc_r;
        pop_s     = !ID_br_ctrl && !hdu_stall && !empty_s;
    end

    // Fetch FSM state, PC and kill flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= REQ;
            fetch_pc_r <= RESET_PC;
            out_pc_r   <= {PC_W{1'b0}};
            kill_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            kill_r     <= kill_next_s;
            if (grant_s) begin
                out_pc_r <= fetch_pc_r;
            end
        end
    end

    // IF/ID register: redirect clears it, stall holds it, otherwise it takes the buffer head.
    always_ff @(posedge clk) begin
        if (reset) begin
            ID_inst  <= NOP_INST;
            ID_pc    <= {PC_W{1'b0}};
            ID_valid <= 1'b0;
        end else if (ID_br_ctrl) begin
            ID_inst  <= NOP_INST;
            ID_pc    <= {PC_W{1'b0}};
            ID_valid <= 1'b0;
        end else if (hdu_stall) begin
            ID_inst  <= ID_inst;
            ID_pc    <= ID_pc;
            ID_valid <= ID_valid;
        end else if (!empty_s) begin
            ID_inst  <= head_s[INST_W-1:0];
            ID_pc    <= head_s[ENT_W-1:INST_W];
            ID_valid <= 1'b1;
        end else begin
            ID_inst  <= NOP_INST;
            ID_valid <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic discard_s;

    // A response is discarded when it returns into a killed slot or meets a redirect.
    always_comb begin
        discard_s = (state_r == WAIT) && imem_rvalid && (kill_r || ID_br_ctrl);
    end

    // Wrapping counters of delivered fetches and of work thrown away.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_killed  <= 32'd0;
        end else begin
            perf_fetched <= perf_fetched + {31'd0, push_s};
            perf_killed  <= perf_killed + {31'd0, discard_s}
                          + (ID_br_ctrl ? {{(32-CNT_W){1'b0}}, count_s} : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a 1-cycle memory returning inst = addr, plus a second
// instance reset to 0xFFFF_FFFC for the grant-delay and PC-wrap cases.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        br;
    logic [15:0] imm;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_killed;
    logic [31:0] w_perf_fetched;
    logic [31:0] w_perf_killed;
`endif

    // Memory responder state
    logic        rsp_pend;
    logic        rsp_hold;
    logic [31:0] rsp_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .ID_br_ctrl  (br),
        .ID_imm_addr (imm),
        .hdu_stall   (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ID_inst     (id_inst),
        .ID_pc       (id_pc),
        .ID_valid    (id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_killed  (perf_killed)
`endif
    );

    if_stage #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .ID_br_ctrl  (1'b0),
        .ID_imm_addr (16'h0000),
        .hdu_stall   (1'b0),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_gnt    (w_gnt),
        .imem_rvalid (w_rvalid),
        .imem_rdata  (w_rdata),
        .ID_inst     (w_inst),
        .ID_pc       (w_pc),
        .ID_valid    (w_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (w_perf_fetched),
        .perf_killed  (w_perf_killed)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: present the memory response for this cycle, grant any request, then
    // return 1 time unit after the rising edge.
    task automatic tick();
        logic        granted;
        logic [31:0] gaddr;
        #1;
        imem_gnt    = imem_req;
        imem_rvalid = rsp_pend & ~rsp_hold;
        imem_rdata  = rsp_pend ? rsp_data : 32'hDEAD_BEEF;
        granted     = imem_gnt;
        gaddr       = imem_addr;
        @(posedge clk);
        if (granted) begin
            rsp_pend = 1'b1;
            rsp_data = gaddr;
        end else if (imem_rvalid) begin
            rsp_pend = 1'b0;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; br = 1'b0; imm = 16'h0000; stall = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
        rsp_pend = 1'b0; rsp_hold = 1'b0; rsp_data = 32'h0;

        // Reset state
        tick(); tick();
        check_bit("rst_valid", id_valid, 1'b0);
        check("rst_inst", id_inst, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check_bit("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
`ifdef IF_PERF_CNT_EN
        check("rst_perf_f", perf_fetched, 32'd0);
        check("rst_perf_k", perf_killed, 32'd0);
`endif
        reset = 1'b0;

        // Streaming: addresses 0,4,8, one instruction every 2 cycles
        tick();
        check_bit("wait_req", imem_req, 1'b0);
        tick();
        check("addr4", imem_addr, 32'h4);
        check_bit("req_again", imem_req, 1'b1);
        check_bit("lat_not_yet", id_valid, 1'b0);
        tick();
        check_bit("v0", id_valid, 1'b1);
        check("inst0", id_inst, 32'h0);
        check("pc0", id_pc, 32'h0);
        tick();
        check_bit("bubble0", id_valid, 1'b0);
        check("addr8", imem_addr, 32'h8);
        tick();
        check_bit("v4", id_valid, 1'b1);
        check("inst4", id_inst, 32'h4);
        check("pc4", id_pc, 32'h4);
        tick();
        check_bit("bubble4", id_valid, 1'b0);
        check("addrC", imem_addr, 32'hC);
        tick();
        check("inst8", id_inst, 32'h8);
        check("pc8", id_pc, 32'h8);

        // Stall for 6 cycles: buffer fills to 2 and requests stop
        stall = 1'b1;
        tick();
        check_bit("stall_req1", imem_req, 1'b1);
        check("stall_addr10", imem_addr, 32'h10);
        tick(); tick();
        check_bit("full_noreq", imem_req, 1'b0);
        tick(); tick(); tick();
        check("stall_hold_inst", id_inst, 32'h8);
        check_bit("stall_hold_valid", id_valid, 1'b1);
        check_bit("full_noreq2", imem_req, 1'b0);
        check("full_addr_held", imem_addr, 32'h14);
        stall = 1'b0;
        tick();
        check("drain0_inst", id_inst, 32'hC);
        check("drain0_pc", id_pc, 32'hC);
        tick();
        check("drain1_inst", id_inst, 32'h10);

        // Build one buffered entry, then redirect with grant of 0x20 under stall
        tick();
        check_bit("empty_bubble", id_valid, 1'b0);
        tick();
        check("inst14", id_inst, 32'h14);
        stall = 1'b1;
        tick();
        check("inst14_held", id_inst, 32'h14);
        stall = 1'b0;
        tick();
        check("inst18", id_inst, 32'h18);
        stall = 1'b1;
        tick();
        check_bit("req20", imem_req, 1'b1);
        check("addr20", imem_addr, 32'h20);
        br = 1'b1; imm = 16'h0042;
        tick();
        br = 1'b0; stall = 1'b0;
        check_bit("flush_valid", id_valid, 1'b0);
        check("flush_inst", id_inst, 32'h0);
        check_bit("kill_wait_req", imem_req, 1'b0);
        tick();
        check_bit("tgt_req", imem_req, 1'b1);
        check("tgt_addr40", imem_addr, 32'h40);
        tick(); tick(); tick();
        check("inst40", id_inst, 32'h40);
        check("pc40", id_pc, 32'h40);
`ifdef IF_PERF_CNT_EN
        check("perf_k2", perf_killed, 32'd2);
        check("perf_f9", perf_fetched, 32'd9);
`endif

        // Redirect to 0x100 while waiting on a late response
        rsp_hold = 1'b1; br = 1'b1; imm = 16'h0100;
        tick();
        br = 1'b0; rsp_hold = 1'b0;
        check_bit("wait_flush_valid", id_valid, 1'b0);
        tick();
        check_bit("after_kill_req", imem_req, 1'b1);
        check("after_kill_addr", imem_addr, 32'h100);
        check_bit("killed_not_seen", id_valid, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("perf_k3", perf_killed, 32'd3);
`endif
        tick(); tick(); tick();
        check("inst100", id_inst, 32'h100);
        check("pc100", id_pc, 32'h100);
`ifdef IF_PERF_CNT_EN
        check("perf_f10", perf_fetched, 32'd10);
`endif

        // Grant held off for 5 cycles, then wrap from 0xFFFF_FFFC
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gnt_delay_addr", w_addr, 32'hFFFF_FFFC);
            check_bit("gnt_delay_req", w_req, 1'b1);
        end
        w_gnt = 1'b1;
        tick();
        w_gnt = 1'b0;
        check_bit("wrap_wait", w_req, 1'b0);
        w_rvalid = 1'b1; w_rdata = 32'h1234_5678;
        tick();
        w_rvalid = 1'b0;
        check("wrap_addr0", w_addr, 32'h0);
        check_bit("wrap_req", w_req, 1'b1);
        tick();
        check("wrap_inst", w_inst, 32'h1234_5678);
        check("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check_bit("wrap_valid", w_valid, 1'b1);
        check_bit("main_in_wait", imem_req, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("wrap_perf_f", w_perf_fetched, 32'd1);
        check("wrap_perf_k", w_perf_killed, 32'd0);
`endif

        // Reset while waiting; the late response must be ignored
        reset = 1'b1; rsp_hold = 1'b1;
        tick();
        check_bit("mid_rst_valid", id_valid, 1'b0);
        check("mid_rst_inst", id_inst, 32'h0);
        check("mid_rst_pc", id_pc, 32'h0);
        check_bit("mid_rst_req", imem_req, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("mid_rst_perf_f", perf_fetched, 32'd0);
        check("mid_rst_perf_k", perf_killed, 32'd0);
`endif
        reset = 1'b0; rsp_hold = 1'b0;
        check("post_rst_addr", imem_addr, 32'h0);
        tick();
        check_bit("post_rst_wait", imem_req, 1'b0);
        tick();
        check_bit("post_rst_bubble", id_valid, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("post_rst_perf_f", perf_fetched, 32'd1);
`endif
        tick();
        check_bit("post_rst_valid", id_valid, 1'b1);
        check("post_rst_inst", id_inst, 32'h0);
        check("post_rst_pc", id_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
